// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a 16-bit-addressed serial EEPROM backed by on-chip RAM.
// It samples SCL and SDA on clk, detects START and STOP, and matches the device address.
// It ACKs each accepted byte, writes data bytes to RAM and drives read data back onto SDA.
`timescale 1ns/1ps
module i2c_eeprom_target #(
  parameter logic [6:0]  DEV_ADDR = 7'b1010_000,
  parameter int unsigned MEM_AW   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        wr_strobe,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, AHI, ACK_AHI, ALO, ACK_ALO,
    WDAT, ACK_WDAT, RDAT, MACK, WAIT
  } state_t;

  state_t      state, state_n;
  logic        scl_s1, scl_s2, scl_d;
  logic        sda_s1, sda_s2, sda_d;
  logic        scl_rise, scl_fall, start_c, stop_c;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [7:0]  shreg, shreg_n, shifted;
  logic [15:0] ptr, ptr_n;
  logic [7:0]  rd_byte, rd_byte_n, mem_rd;
  logic        rw, rw_n;
  logic        ack_ph, ack_ph_n;
  logic        sda_oe_n, busy_n, wr_en;
  logic [7:0]  mem [2**MEM_AW];

  // Two-stage synchronizers plus one history stage, idling high like the bus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= scl_in; scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= sda_in; sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  assign start_c  = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_c   = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign shifted  = {shreg[6:0], sda_s2};
  assign mem_rd   = mem[ptr[MEM_AW-1:0]];

  // Next-state logic: START/STOP override everything; bits sampled on SCL rise, SDA driven on SCL fall.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    rd_byte_n = rd_byte;
    rw_n      = rw;
    ack_ph_n  = ack_ph;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    wr_en     = 1'b0;
    if (stop_c) begin
      state_n   = IDLE;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      bit_cnt_n = '0;
      ack_ph_n  = 1'b0;
    end else if (start_c) begin
      state_n   = DEV;
      sda_oe_n  = 1'b0;
      bit_cnt_n = '0;
      ack_ph_n  = 1'b0;
    end else begin
      case (state)
        DEV, AHI, ALO, WDAT: begin
          if (scl_rise) begin
            shreg_n   = shifted;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ack_ph_n = 1'b0;
              case (state)
                DEV: begin
                  if (shifted[7:1] == DEV_ADDR) begin
                    state_n = ACK_DEV;
                    rw_n    = shifted[0];
                    busy_n  = 1'b1;
                  end else begin
                    state_n = WAIT;
                    busy_n  = 1'b0;
                  end
                end
                AHI: begin
                  ptr_n[15:8] = shifted;
                  state_n     = ACK_AHI;
                end
                ALO: begin
                  ptr_n[7:0] = shifted;
                  state_n    = ACK_ALO;
                end
                default: begin
                  wr_en   = 1'b1;
                  ptr_n   = ptr + 16'd1;
                  state_n = ACK_WDAT;
                end
              endcase
            end
          end
        end
        // First fall after the 8th bit pulls SDA low; the fall ending the 9th clock releases it.
        ACK_DEV, ACK_AHI, ACK_ALO, ACK_WDAT: begin
          if (scl_fall) begin
            if (!ack_ph) begin
              sda_oe_n = 1'b1;
              ack_ph_n = 1'b1;
            end else begin
              ack_ph_n  = 1'b0;
              bit_cnt_n = '0;
              sda_oe_n  = 1'b0;
              case (state)
                ACK_DEV: begin
                  if (rw) begin
                    state_n   = RDAT;
                    rd_byte_n = mem_rd;
                    sda_oe_n  = ~mem_rd[7];
                  end else begin
                    state_n = AHI;
                  end
                end
                ACK_AHI: state_n = ALO;
                default: state_n = WDAT;
              endcase
            end
          end
        end
        // Bit 7 is already on the bus when RDAT is entered; a wrapped counter marks the 8th fall.
        RDAT: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_oe_n = 1'b0;
              ack_ph_n = 1'b0;
              state_n  = MACK;
            end else begin
              sda_oe_n = ~rd_byte[3'd7 - bit_cnt];
            end
          end
        end
        MACK: begin
          if (!ack_ph) begin
            if (scl_rise) begin
              if (sda_s2) begin
                state_n = WAIT;
                busy_n  = 1'b0;
              end else begin
                ptr_n    = ptr + 16'd1;
                ack_ph_n = 1'b1;
              end
            end
          end else if (scl_fall) begin
            ack_ph_n  = 1'b0;
            bit_cnt_n = '0;
            rd_byte_n = mem_rd;
            sda_oe_n  = ~mem_rd[7];
            state_n   = RDAT;
          end
        end
        default: ;
      endcase
    end
  end

  // Protocol state and output registers; reset releases SDA asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rd_byte   <= '0;
      rw        <= 1'b0;
      ack_ph    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      ptr       <= ptr_n;
      rd_byte   <= rd_byte_n;
      rw        <= rw_n;
      ack_ph    <= ack_ph_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      wr_strobe <= wr_en;
      if (wr_en) begin
        wr_addr <= ptr;
        wr_data <= shifted;
      end
    end
  end

  // Byte storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr[MEM_AW-1:0]] <= shifted;
  end

endmodule
